mem_access_unit: RTL

- Initiator-side controller for the single-port data RAM. It accepts one load/store request at a time from the pipeline over a valid/ready handshake.
- Validates alignment, range and width, then drives the RAM's address/access-mode/width/data pins for exactly one cycle.
- Captures the RAM's registered read data and returns a response (data plus fault flag) over a second valid/ready handshake.
- Sits between the execute/memory stage and the RAM.

---
 rtl/mem_access_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Initiator-side controller for the single-port data RAM: validates one load/store
// request, drives the RAM pins for one cycle, then returns data and a fault flag.
module mem_access_unit #(
  parameter int unsigned DATA_LEN = 64,
  parameter int unsigned RAM_SIZE = 12,
  parameter int unsigned ADDR_LEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic [ADDR_LEN-1:0] req_addr_i,
  input  logic [DATA_LEN-1:0] req_wdata_i,
  input  logic [2:0]          req_memwid_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_LEN-1:0] rsp_rdata_o,
  output logic                rsp_fault_o,
  output logic [RAM_SIZE-1:0] ram_addr_o,
  output logic [1:0]          ram_access_mode_o,
  output logic [2:0]          ram_memwid_o,
  output logic [DATA_LEN-1:0] ram_data_o,
  input  logic [DATA_LEN-1:0] ram_data_i,
  input  logic                ram_illegal_i
);

  localparam logic [1:0] ModeNone  = 2'd0;
  localparam logic [1:0] ModeRead  = 2'd1;
  localparam logic [1:0] ModeWrite = 2'd2;

  typedef enum logic [1:0] {StIdle, StIssue, StCapt, StResp} state_e;

  state_e state_q;
  logic   write_q;
  logic   fault_q;
  logic   req_fault;

  // Requests that would misbehave in the RAM are rejected before it ever sees them.
  always_comb begin
    req_fault = 1'b0;
    if (req_addr_i[2:0] != 3'b000)                     req_fault = 1'b1;
    if (req_addr_i[ADDR_LEN-1:RAM_SIZE+3] != '0)       req_fault = 1'b1;
    if (req_memwid_i == 3'b111)                        req_fault = 1'b1;
    if (req_write_i && req_memwid_i[2])                req_fault = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      write_q           <= 1'b0;
      fault_q           <= 1'b0;
      req_ready_o       <= 1'b1;
      rsp_valid_o       <= 1'b0;
      rsp_rdata_o       <= '0;
      rsp_fault_o       <= 1'b0;
      ram_addr_o        <= '0;
      ram_access_mode_o <= ModeNone;
      ram_memwid_o      <= '0;
      ram_data_o        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            write_q     <= req_write_i;
            if (req_fault) begin
              state_q     <= StResp;
              rsp_valid_o <= 1'b1;
              rsp_fault_o <= 1'b1;
              rsp_rdata_o <= '0;
            end else begin
              state_q           <= StIssue;
              ram_addr_o        <= req_addr_i[RAM_SIZE+2:3];
              ram_memwid_o      <= req_memwid_i;
              ram_data_o        <= req_wdata_i;
              ram_access_mode_o <= req_write_i ? ModeWrite : ModeRead;
            end
          end
        end
        StIssue: begin
          // The RAM acts on this edge; its illegal flag is only meaningful now.
          fault_q           <= ram_illegal_i;
          ram_access_mode_o <= ModeNone;
          state_q           <= StCapt;
        end
        StCapt: begin
          rsp_rdata_o <= (!write_q && !fault_q) ? ram_data_i : '0;
          rsp_fault_o <= fault_q;
          rsp_valid_o <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
